// File: rtl/lfsr_source.sv
// lfsr_source
//   Seedable 14-bit maximal-length LFSR pattern source (x^14+x^5+x^3+x+1,
//   period 16383) with a simple IDLE/RUN sequencer and a period counter.
//
//   Ports
//     clk         system clock, rising edge
//     reset       asynchronous, active-high reset
//     seed_in     candidate seed (zero is replaced by SEED_DEFAULT)
//     seed_load   latch seed_in into the seed register and LFSR (IDLE only)
//     start       enter RUN, reload LFSR from seed, clear period_cnt (IDLE only)
//     stop        return to IDLE, LFSR holds (RUN only)
//     step_en     advance the LFSR one step per cycle while in RUN
//     lfsr_out    current LFSR state (registered)
//     msb_out     lfsr_out[13]
//     max_tick    RUN and lfsr_out equals the seed register (registered)
//     running     FSM is in RUN (registered)
//     period_cnt  full periods since last start, saturating at 255
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | not generating; seed may be loaded, start is honoured
//   RUN   | generating; step_en advances the LFSR, stop returns to IDLE

module lfsr_source #(
    parameter logic [13:0] SEED_DEFAULT = 14'h0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] seed_in,
    input  logic        seed_load,
    input  logic        start,
    input  logic        stop,
    input  logic        step_en,
    output logic [13:0] lfsr_out,
    output logic        msb_out,
    output logic        max_tick,
    output logic        running,
    output logic [7:0]  period_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_n;
    logic [13:0] seed_q;
    logic [13:0] seed_n;
    logic [13:0] lfsr_n;
    logic [7:0]  cnt_n;
    logic        max_tick_n;
    logic [13:0] load_val;
    logic [13:0] step_val;
    logic        fb;

    // A zero seed would lock the LFSR up, so it is swapped for the default.
    assign load_val = (seed_in == 14'd0) ? SEED_DEFAULT : seed_in;

    assign fb       = lfsr_out[13] ^ lfsr_out[4] ^ lfsr_out[2] ^ lfsr_out[0];
    assign step_val = {lfsr_out[12:0], fb};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic; stop wins over start in IDLE so the pair is a no-op.
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (start && !stop) state_n = RUN;
            RUN:     if (stop)           state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        seed_n = seed_q;
        lfsr_n = lfsr_out;
        cnt_n  = period_cnt;
        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    seed_n = load_val;
                    lfsr_n = load_val;
                end
                // seed_n already carries a same-cycle seed_load, so a combined
                // load+start runs from the new seed.
                if (start && !stop) begin
                    lfsr_n = seed_n;
                    cnt_n  = 8'd0;
                end
            end
            RUN: begin
                if (!stop && step_en) begin
                    lfsr_n = step_val;
                    if (step_val == seed_q && period_cnt != 8'd255) begin
                        cnt_n = period_cnt + 8'd1;
                    end
                end
            end
            default: ;
        endcase
        // Registered version of "RUN and lfsr_out == seed": evaluate on next values.
        max_tick_n = (state_n == RUN) && (lfsr_n == seed_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seed_q     <= SEED_DEFAULT;
            lfsr_out   <= SEED_DEFAULT;
            period_cnt <= 8'd0;
            max_tick   <= 1'b0;
            running    <= 1'b0;
        end else begin
            seed_q     <= seed_n;
            lfsr_out   <= lfsr_n;
            period_cnt <= cnt_n;
            max_tick   <= max_tick_n;
            running    <= (state_n == RUN);
        end
    end

    assign msb_out = lfsr_out[13];

endmodule

// File: tb/tb_lfsr_source.sv
// tb_lfsr_source
//   Self-checking bench for lfsr_source. Each driven cycle pushes the
//   expected post-edge outputs from a behavioural model onto a scoreboard
//   queue; the entry is popped and compared one time unit after the edge.

module tb_lfsr_source;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] seed_in;
    logic        seed_load;
    logic        start;
    logic        stop;
    logic        step_en;
    logic [13:0] lfsr_out;
    logic        msb_out;
    logic        max_tick;
    logic        running;
    logic [7:0]  period_cnt;

    lfsr_source dut (
        .clk        (clk),
        .reset      (reset),
        .seed_in    (seed_in),
        .seed_load  (seed_load),
        .start      (start),
        .stop       (stop),
        .step_en    (step_en),
        .lfsr_out   (lfsr_out),
        .msb_out    (msb_out),
        .max_tick   (max_tick),
        .running    (running),
        .period_cnt (period_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] lfsr;
        logic        mt;
        logic        run;
        logic [7:0]  pc;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic        m_run;
    logic [13:0] m_seed;
    logic [13:0] m_lfsr;
    logic [7:0]  m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [13:0] model_step(input logic [13:0] s);
        logic b;
        b = s[13] ^ s[4] ^ s[2] ^ s[0];
        return {s[12:0], b};
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_seed = 14'h0001;
        m_lfsr = 14'h0001;
        m_cnt  = 8'd0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".lfsr"}, lfsr_out, 14'h0001);
        chk({tag, ".msb"},  msb_out, 1'b0);
        chk({tag, ".mt"},   max_tick, 1'b0);
        chk({tag, ".run"},  running, 1'b0);
        chk({tag, ".pc"},   period_cnt, 8'd0);
    endtask

    // Drive one cycle of inputs, predict, clock, then compare.
    task automatic cycle(input string tag, input logic sl, input logic [13:0] si,
                         input logic st, input logic sp, input logic se);
        exp_t e;
        logic [13:0] nx;
        seed_load = sl;
        seed_in   = si;
        start     = st;
        stop      = sp;
        step_en   = se;
        if (!m_run) begin
            if (sl) begin
                m_seed = (si == 14'd0) ? 14'h0001 : si;
                m_lfsr = m_seed;
            end
            if (st && !sp) begin
                m_run  = 1'b1;
                m_lfsr = m_seed;
                m_cnt  = 8'd0;
            end
        end else if (sp) begin
            m_run = 1'b0;
        end else if (se) begin
            nx     = model_step(m_lfsr);
            m_lfsr = nx;
            if (nx == m_seed && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        end
        e.lfsr = m_lfsr;
        e.mt   = m_run && (m_lfsr == m_seed);
        e.run  = m_run;
        e.pc   = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".lfsr"}, lfsr_out, e.lfsr);
        chk({tag, ".msb"},  msb_out, e.lfsr[13]);
        chk({tag, ".mt"},   max_tick, e.mt);
        chk({tag, ".run"},  running, e.run);
        chk({tag, ".pc"},   period_cnt, e.pc);
    endtask

    logic [13:0] ref30 [5];
    int msb_ones;
    logic [13:0] held;

    initial begin
        ref30[0] = 14'h0001; ref30[1] = 14'h0003; ref30[2] = 14'h0007;
        ref30[3] = 14'h000E; ref30[4] = 14'h001D;

        // Reset with every control input active: all must be ignored.
        reset = 1'b1; seed_in = 14'h1234; seed_load = 1'b1;
        start = 1'b1; stop = 1'b0; step_en = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_reset_values("reset");
        seed_load = 1'b0; start = 1'b0; step_en = 1'b0; seed_in = 14'd0;
        reset = 1'b0;

        // Idle cycle, then start + 4 steps from the default seed.
        cycle("idle", 0, 14'h0, 0, 0, 0);
        cycle("start", 0, 14'h0, 1, 0, 0);
        chk("s30.first", lfsr_out, ref30[0]);
        chk("s30.mt0", max_tick, 1'b1);
        for (int i = 1; i < 5; i++) begin
            cycle("s30.step", 0, 14'h0, 0, 0, 1);
            chk("s30.val", lfsr_out, ref30[i]);
            chk("s30.mt", max_tick, 1'b0);
        end

        // seed_load and start in RUN are ignored.
        cycle("run.load", 1, 14'h1111, 0, 0, 1);
        cycle("run.start", 0, 14'h0, 1, 0, 1);

        // stop with step_en: no step, back to IDLE.
        held = lfsr_out;
        cycle("stop", 0, 14'h0, 0, 1, 1);
        chk("stop.hold", lfsr_out, held);
        cycle("idle.step", 0, 14'h0, 0, 0, 1);
        chk("idle.hold", lfsr_out, held);

        // start + stop together in IDLE stays IDLE.
        cycle("st+sp", 0, 14'h0, 1, 1, 0);

        // Zero seed is replaced by the default.
        cycle("load0", 1, 14'h0000, 0, 0, 0);
        chk("load0.lfsr", lfsr_out, 14'h0001);
        cycle("start0", 0, 14'h0, 1, 0, 0);
        chk("start0.mt", max_tick, 1'b1);

        // Hold in RUN with step_en low: max_tick stays high.
        for (int i = 0; i < 3; i++) cycle("hold", 0, 14'h0, 0, 0, 0);
        chk("hold.mt", max_tick, 1'b1);
        cycle("step", 0, 14'h0, 0, 0, 1);
        cycle("stop2", 0, 14'h0, 0, 1, 0);

        // seed_load together with start: new seed used immediately.
        cycle("load+start", 1, 14'h0155, 1, 0, 0);
        chk("ls.lfsr", lfsr_out, 14'h0155);
        cycle("stop3", 0, 14'h0, 0, 1, 0);

        // Full period from 0x2A5C.
        cycle("load2A5C", 1, 14'h2A5C, 0, 0, 0);
        cycle("start2A5C", 0, 14'h0, 1, 0, 0);
        msb_ones = 0;
        for (int i = 0; i < 16383; i++) begin
            msb_ones += int'(msb_out);
            cycle("period", 0, 14'h0, 0, 0, 1);
        end
        chk("period.lfsr", lfsr_out, 14'h2A5C);
        chk("period.mt", max_tick, 1'b1);
        chk("period.pc", period_cnt, 8'd1);
        chk("period.msb_ones", msb_ones, 8192);

        // Restart clears period_cnt.
        cycle("stop4", 0, 14'h0, 0, 1, 0);
        cycle("restart", 0, 14'h0, 1, 0, 0);
        chk("restart.pc", period_cnt, 8'd0);

        // 100 steps, then asynchronous reset between edges.
        for (int i = 0; i < 100; i++) cycle("pre_rst", 0, 14'h0, 0, 0, 1);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(posedge clk); #1;
        check_reset_values("rst_hold");
        reset = 1'b0;
        cycle("after_rst", 0, 14'h0, 0, 0, 1);
        cycle("after_rst.start", 0, 14'h0, 1, 0, 0);
        cycle("after_rst.step", 0, 14'h0, 0, 0, 1);
        chk("after_rst.val", lfsr_out, 14'h0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_source.md
LFSR_SOURCE -- requirements
Module: lfsr_source

Interface
REQ-001 Parameter SEED_DEFAULT, 14'h0001: seed used at reset and whenever a zero seed is loaded.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 seed_in  input  14  candidate seed value.
REQ-005 seed_load  input  1  latches seed_in into the seed register; honoured only in IDLE.
REQ-006 start  input  1  begins sequence generation; honoured only in IDLE.
REQ-007 stop  input  1  ends sequence generation; honoured only in RUN.
REQ-008 step_en  input  1  advances the LFSR by one step per cycle while in RUN.
REQ-009 lfsr_out  output  14  current LFSR state, registered.
REQ-010 msb_out  output  1  lfsr_out[13], directly from the register with no added latency.
REQ-011 max_tick  output  1  high in every cycle where the block is in RUN and lfsr_out equals the seed register.
REQ-012 running  output  1  high when the FSM is in RUN.
REQ-013 period_cnt  output  8  number of full periods completed since the last start; saturates at 255.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and RUN; running SHALL equal (state == RUN).
REQ-015 IDLE -> RUN SHALL occur when start=1 and stop=0; start and stop together in IDLE SHALL leave the FSM in IDLE.
REQ-016 RUN -> IDLE SHALL occur when stop=1; start SHALL be ignored while in RUN.
REQ-017 seed_load in IDLE SHALL write seed_in to seed_reg and lfsr_out, substituting SEED_DEFAULT if seed_in is 0; seed_load in RUN SHALL be ignored.
REQ-018 A start SHALL reload lfsr_out from the effective seed and clear period_cnt to 0.
REQ-019 If seed_load and start are both asserted in IDLE, the new seed SHALL take effect, so lfsr_out = new seed in the first RUN cycle.
REQ-020 In RUN, when step_en=1 and stop=0, the next state SHALL be lfsr_out = {lfsr_out[12:0], fb}, where fb = lfsr_out[13]^lfsr_out[4]^lfsr_out[2]^lfsr_out[0] (polynomial x^14+x^5+x^3+x+1, period 16383).
REQ-021 When step_en=0 in RUN, lfsr_out SHALL hold its value; max_tick SHALL stay high for as long as the held value equals seed_reg.
REQ-022 stop together with step_en SHALL take priority: no step occurs, and lfsr_out holds its value in IDLE.
REQ-023 max_tick SHALL be 0 in IDLE regardless of lfsr_out.
REQ-024 period_cnt SHALL increment by 1 on each step whose result equals seed_reg; at 255 it SHALL hold at 255.
REQ-025 The all-zero state SHALL be unreachable: lfsr_out is never 0 after reset or after any load.
REQ-026 All outputs except msb_out SHALL be registered; msb_out has zero added latency relative to lfsr_out.

Reset
REQ-027 While reset=1, state SHALL be IDLE, seed_reg = lfsr_out = SEED_DEFAULT, running=0, max_tick=0, period_cnt=0, and msb_out=0 (with the default seed).
REQ-028 Reset asserted mid-RUN SHALL take effect immediately, without waiting for a clock edge; the first cycle after release SHALL be IDLE with the reset values.
REQ-029 seed_load, start, stop and step_en SHALL be ignored while reset=1.

Verification
REQ-030 Scenario: reset, then start, then step_en=1 for 4 cycles -> lfsr_out = 0x0001, 0x0003, 0x0007, 0x000E, 0x001D; max_tick=1 only in the first RUN cycle.
REQ-031 Scenario: seed_load with 0x2A5C, then start, then step_en held high for 16383 cycles -> lfsr_out = 0x2A5C again, max_tick=1, period_cnt=1; msb_out is 1 in exactly 8192 of the 16383 states in one period.
REQ-032 Scenario: seed_load with 0x0000 -> seed_reg = lfsr_out = 0x0001; start then gives max_tick=1.
REQ-033 Scenario: in RUN, stop together with step_en -> running=0 next cycle, lfsr_out unchanged, max_tick=0; a later start reloads the seed and sets period_cnt=0.
REQ-034 Scenario: seed_load in RUN, and start in RUN -> no change to seed_reg, lfsr_out sequence or period_cnt.
REQ-035 Scenario: reset pulse between clock edges after 100 steps -> outputs immediately return to the REQ-027 values; running=0.
